// File: rtl/ysyx_23060020_mc_contr.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, control decode, halt handling.
// Optional performance counters are enabled with YSYX_23060020_CONTR_PERF_EN.
module ysyx_23060020_mc_contr #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifu_req,
    input  logic            ifu_valid,
    input  logic [31:0]     ifu_inst,
    output logic            lsu_req,
    output logic            lsu_wen,
    input  logic            lsu_done,
    input  logic            br_taken,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic            aluamux,
    output logic            alubmux,
    output logic [3:0]      alu_op,
    output logic [1:0]      wb_sel,
    output logic [1:0]      pc_sel,
    output logic            rfwen,
    output logic            pc_wen,
    output logic            halt,
    output logic [1:0]      halt_code,
    output logic [2:0]      state
`ifdef YSYX_23060020_CONTR_PERF_EN
    ,
    output logic [63:0]     perf_cycles,
    output logic [63:0]     perf_instret
`endif
);

    localparam int unsigned CNT_W = 16;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;

    localparam logic [1:0] HC_EBREAK  = 2'd1;
    localparam logic [1:0] HC_ILLEGAL = 2'd2;
    localparam logic [1:0] HC_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        C_OPIMM, C_OP, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LW, C_SW
    } cls_e;

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d;
    logic [31:0]       inst_q, inst_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic              amux_q, amux_d, bmux_q, bmux_d;
    logic [3:0]        alu_q, alu_d;
    logic [1:0]        wb_q, wb_d, pcs_q, pcs_d, hcode_q, hcode_d;
    logic              ifu_req_q, ifu_req_d, lsu_req_q, lsu_req_d, lsu_wen_q, lsu_wen_d;
    logic              rfwen_q, rfwen_d, pc_wen_q, pc_wen_d, halt_q, halt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] dec_imm32;
    cls_e        dec_cls;
    logic        dec_ok, dec_ebreak, dec_amux, dec_bmux, writes_rd;
    logic [3:0]  dec_alu;
    logic [1:0]  dec_wb, dec_pcs;

    assign opcode = inst_q[6:0];
    assign funct3 = inst_q[14:12];
    assign funct7 = inst_q[31:25];
    assign imm_i  = {{20{inst_q[31]}}, inst_q[31:20]};
    assign imm_s  = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
    assign imm_b  = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    assign imm_u  = {inst_q[31:12], 12'd0};
    assign imm_j  = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
    assign dec_ebreak = (inst_q == 32'h0010_0073);
    assign writes_rd  = (cls_q != C_BRANCH) && (cls_q != C_SW) && (inst_q[11:7] != 5'd0);

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_f3 = ALU_SLL;
            3'b010:  alu_from_f3 = ALU_SLT;
            3'b011:  alu_from_f3 = ALU_SLTU;
            3'b100:  alu_from_f3 = ALU_XOR;
            3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

    // Instruction decode of the latched word; consumed only in DECODE.
    always_comb begin
        dec_imm32 = 32'd0;
        dec_cls   = C_OP;
        dec_ok    = 1'b1;
        dec_alu   = ALU_ADD;
        dec_amux  = 1'b0;
        dec_bmux  = 1'b0;
        dec_wb    = 2'd0;
        dec_pcs   = 2'd0;
        case (opcode)
            OPC_OPIMM: begin
                dec_cls   = C_OPIMM;
                dec_imm32 = imm_i;
                dec_bmux  = 1'b1;
                dec_alu   = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001)      dec_ok = (funct7 == 7'h00);
                else if (funct3 == 3'b101) dec_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
            end
            OPC_OP: begin
                dec_cls = C_OP;
                dec_alu = alu_from_f3(funct3, funct7[5]);
                dec_ok  = (funct7 == 7'h00) ||
                          ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_LUI: begin
                dec_cls   = C_LUI;
                dec_imm32 = imm_u;
                dec_bmux  = 1'b1;
                dec_alu   = ALU_PASSB;
            end
            OPC_AUIPC: begin
                dec_cls   = C_AUIPC;
                dec_imm32 = imm_u;
                dec_amux  = 1'b1;
                dec_bmux  = 1'b1;
            end
            OPC_JAL: begin
                dec_cls   = C_JAL;
                dec_imm32 = imm_j;
                dec_wb    = 2'd2;
                dec_pcs   = 2'd1;
            end
            OPC_JALR: begin
                dec_cls   = C_JALR;
                dec_imm32 = imm_i;
                dec_wb    = 2'd2;
                dec_pcs   = 2'd2;
                dec_ok    = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec_cls   = C_BRANCH;
                dec_imm32 = imm_b;
                case (funct3)
                    3'b000, 3'b001: dec_alu = ALU_SUB;
                    3'b100, 3'b101: dec_alu = ALU_SLT;
                    3'b110, 3'b111: dec_alu = ALU_SLTU;
                    default:        dec_ok  = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec_cls   = C_LW;
                dec_imm32 = imm_i;
                dec_bmux  = 1'b1;
                dec_wb    = 2'd1;
                dec_ok    = (funct3 == 3'b010);
            end
            OPC_STORE: begin
                dec_cls   = C_SW;
                dec_imm32 = imm_s;
                dec_bmux  = 1'b1;
                dec_ok    = (funct3 == 3'b010);
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        inst_d  = inst_q;
        imm_d   = imm_q;
        amux_d  = amux_q;
        bmux_d  = bmux_q;
        alu_d   = alu_q;
        wb_d    = wb_q;
        pcs_d   = pcs_q;
        hcode_d = hcode_q;
        cnt_d   = '0;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: begin
                if (ifu_valid) begin
                    inst_d  = ifu_inst;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_ebreak) begin
                    hcode_d = HC_EBREAK;
                    state_d = S_HALT;
                end else if (!dec_ok) begin
                    hcode_d = HC_ILLEGAL;
                    state_d = S_HALT;
                end else begin
                    cls_d   = dec_cls;
                    imm_d   = XLEN'($signed(dec_imm32));
                    amux_d  = dec_amux;
                    bmux_d  = dec_bmux;
                    alu_d   = dec_alu;
                    wb_d    = dec_wb;
                    pcs_d   = dec_pcs;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls_q == C_BRANCH) pcs_d = br_taken ? 2'd1 : 2'd0;
                state_d = ((cls_q == C_LW) || (cls_q == C_SW)) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // lsu_done takes priority over a timeout in the same cycle
                if (lsu_done) begin
                    state_d = S_WB;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    hcode_d = HC_TIMEOUT;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
        ifu_req_d = (state_d == S_FETCH);
        lsu_req_d = (state_d == S_MEM);
        lsu_wen_d = (state_d == S_MEM) && (cls_q == C_SW);
        pc_wen_d  = (state_d == S_WB);
        rfwen_d   = (state_d == S_WB) && writes_rd;
        halt_d    = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RST;
            cls_q     <= C_OPIMM;
            inst_q    <= '0;
            imm_q     <= '0;
            amux_q    <= 1'b0;
            bmux_q    <= 1'b0;
            alu_q     <= '0;
            wb_q      <= '0;
            pcs_q     <= '0;
            hcode_q   <= '0;
            cnt_q     <= '0;
            ifu_req_q <= 1'b0;
            lsu_req_q <= 1'b0;
            lsu_wen_q <= 1'b0;
            rfwen_q   <= 1'b0;
            pc_wen_q  <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            inst_q    <= inst_d;
            imm_q     <= imm_d;
            amux_q    <= amux_d;
            bmux_q    <= bmux_d;
            alu_q     <= alu_d;
            wb_q      <= wb_d;
            pcs_q     <= pcs_d;
            hcode_q   <= hcode_d;
            cnt_q     <= cnt_d;
            ifu_req_q <= ifu_req_d;
            lsu_req_q <= lsu_req_d;
            lsu_wen_q <= lsu_wen_d;
            rfwen_q   <= rfwen_d;
            pc_wen_q  <= pc_wen_d;
            halt_q    <= halt_d;
        end
    end

    assign ifu_req   = ifu_req_q;
    assign lsu_req   = lsu_req_q;
    assign lsu_wen   = lsu_wen_q;
    assign inst      = inst_q;
    assign imm       = imm_q;
    assign aluamux   = amux_q;
    assign alubmux   = bmux_q;
    assign alu_op    = alu_q;
    assign wb_sel    = wb_q;
    assign pc_sel    = pcs_q;
    assign rfwen     = rfwen_q;
    assign pc_wen    = pc_wen_q;
    assign halt      = halt_q;
    assign halt_code = hcode_q;
    assign state     = state_q;

`ifdef YSYX_23060020_CONTR_PERF_EN
    logic [63:0] perf_cycles_q, perf_cycles_d, perf_instret_q, perf_instret_d;

    // Counters naturally freeze in HALT and are cleared by reset.
    always_comb begin
        perf_cycles_d  = perf_cycles_q;
        perf_instret_d = perf_instret_q;
        if ((state_q != S_RST) && (state_q != S_HALT)) perf_cycles_d = perf_cycles_q + 64'd1;
        if (state_q == S_WB) perf_instret_d = perf_instret_q + 64'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_q  <= '0;
            perf_instret_q <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_instret_q <= perf_instret_d;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_instret = perf_instret_q;
`endif

endmodule

// File: tb/tb_ysyx_23060020_mc_contr.sv
// Self-checking bench for ysyx_23060020_mc_contr: instructions are built from random fields by an
// encoder model that also yields the expected controls; the bench walks each one through the FSM.
module tb_ysyx_23060020_mc_contr;
    localparam int unsigned TMO = 4;
    localparam int K_OPIMM = 0, K_OP = 1, K_LUI = 2, K_AUIPC = 3, K_JAL = 4;
    localparam int K_JALR = 5, K_BR = 6, K_LW = 7, K_SW = 8, K_HALT = 9;

    logic        clk, rst, ifu_valid, lsu_done, br_taken;
    logic [31:0] ifu_inst;
    logic        ifu_req, lsu_req, lsu_wen, aluamux, alubmux, rfwen, pc_wen, halt;
    logic [31:0] inst, imm;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel, pc_sel, halt_code;
    logic [2:0]  state;
`ifdef YSYX_23060020_CONTR_PERF_EN
    logic [63:0] perf_cycles, perf_instret;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] inst;
        int          kind;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        amux, bmux;
        logic [1:0]  wb, pcs, hcode;
        logic        wr, mem, store;
        logic        chk_imm, chk_alu, chk_mux, chk_wb;
    } exp_t;

    int oi_f3[9]   = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
    int oi_alu[9]  = '{0, 3, 4, 5, 8, 9, 2, 6, 7};
    int op_f3[10]  = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int op_f7[10]  = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    int op_alu[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    int br_f3[6]   = '{0, 1, 4, 5, 6, 7};
    int br_alu[6]  = '{1, 1, 3, 3, 4, 4};
    logic [31:0] ill[7] = '{32'hFFFFFFFF, 32'h00000000, 32'h02000033, 32'h00002063,
                            32'h00000003, 32'h40001013, 32'h00000073};

    wire [84:0] outs_all = {ifu_req, lsu_req, lsu_wen, inst, imm, aluamux, alubmux, alu_op,
                            wb_sel, pc_sel, rfwen, pc_wen, halt, halt_code, state};

    ysyx_23060020_mc_contr #(.XLEN(32), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_valid(ifu_valid), .ifu_inst(ifu_inst),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_done(lsu_done), .br_taken(br_taken),
        .inst(inst), .imm(imm), .aluamux(aluamux), .alubmux(alubmux), .alu_op(alu_op),
        .wb_sel(wb_sel), .pc_sel(pc_sel), .rfwen(rfwen), .pc_wen(pc_wen), .halt(halt),
        .halt_code(halt_code), .state(state)
`ifdef YSYX_23060020_CONTR_PERF_EN
        , .perf_cycles(perf_cycles), .perf_instret(perf_instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder model: assemble an instruction from fields and state what the decoder must produce.
    task automatic gen(input int kind, input int rd, input int rs1, input int rs2,
                       input int v, input int sel, output exp_t e);
        logic [31:0] vv;
        logic [4:0]  d, s1, s2;
        vv = v; d = 5'(rd); s1 = 5'(rs1); s2 = 5'(rs2);
        e = '{default: '0};
        e.kind = kind; e.imm = vv; e.wr = (rd != 0);
        e.chk_imm = 1'b1; e.chk_alu = 1'b1; e.chk_mux = 1'b1; e.chk_wb = 1'b1;
        case (kind)
            K_OPIMM: begin
                if (sel >= 6) vv = ((sel == 8) ? 32'h400 : 32'h0) + 32'(v & 31);
                e.inst = {vv[11:0], s1, 3'(oi_f3[sel]), d, 7'h13};
                e.imm = vv; e.alu = 4'(oi_alu[sel]); e.bmux = 1'b1;
            end
            K_OP: begin
                e.inst = {7'(op_f7[sel]), s2, s1, 3'(op_f3[sel]), d, 7'h33};
                e.alu = 4'(op_alu[sel]); e.chk_imm = 1'b0;
            end
            K_LUI: begin
                e.inst = {vv[19:0], d, 7'h37}; e.imm = vv << 12; e.alu = 4'd10; e.bmux = 1'b1;
            end
            K_AUIPC: begin
                e.inst = {vv[19:0], d, 7'h17}; e.imm = vv << 12; e.amux = 1'b1; e.bmux = 1'b1;
            end
            K_JAL: begin
                e.inst = {vv[20], vv[10:1], vv[11], vv[19:12], d, 7'h6F};
                e.wb = 2'd2; e.pcs = 2'd1; e.chk_alu = 1'b0; e.chk_mux = 1'b0;
            end
            K_JALR: begin
                e.inst = {vv[11:0], s1, 3'b000, d, 7'h67};
                e.wb = 2'd2; e.pcs = 2'd2; e.chk_alu = 1'b0; e.chk_mux = 1'b0;
            end
            K_BR: begin
                e.inst = {vv[12], vv[10:5], s2, s1, 3'(br_f3[sel]), vv[4:1], vv[11], 7'h63};
                e.alu = 4'(br_alu[sel]); e.wr = 1'b0; e.chk_wb = 1'b0; e.chk_mux = 1'b0;
            end
            K_LW: begin
                e.inst = {vv[11:0], s1, 3'b010, d, 7'h03};
                e.bmux = 1'b1; e.wb = 2'd1; e.mem = 1'b1;
            end
            K_SW: begin
                e.inst = {vv[11:5], s2, s1, 3'b010, vv[4:0], 7'h23};
                e.bmux = 1'b1; e.mem = 1'b1; e.store = 1'b1; e.wr = 1'b0; e.chk_wb = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic gen_rand(input int kind, output exp_t e);
        int sel, v;
        sel = 0;
        case (kind)
            K_OPIMM: begin
                sel = int'($urandom_range(0, 8));
                v = (sel < 6) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 31));
            end
            K_OP: begin sel = int'($urandom_range(0, 9)); v = 0; end
            K_LUI, K_AUIPC: v = int'($urandom_range(0, 1048575));
            K_JAL: v = int'($urandom_range(0, 1048575)) * 2 - 1048576;
            K_BR: begin
                sel = int'($urandom_range(0, 5));
                v = int'($urandom_range(0, 4095)) * 2 - 4096;
            end
            default: v = int'($urandom_range(0, 4095)) - 2048;
        endcase
        gen(kind, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), v, sel, e);
    endtask

    task automatic mk_halt(input logic [31:0] w, input logic [1:0] code, output exp_t e);
        e = '{default: '0};
        e.inst = w; e.kind = K_HALT; e.hcode = code;
    endtask

    // Walks one instruction from FETCH; mw is the MEM cycle that sees lsu_done (0 = never).
    task automatic run_inst(input exp_t e, input int stall, input bit br, input int mw);
        logic [1:0] xpcs;
        for (int i = 0; i < stall; i++) begin
            ifu_valid = 1'b0; ifu_inst = $urandom; lsu_done = 1'b1;
            @(posedge clk); @(negedge clk);
            total++;
            if ({state, ifu_req} !== {3'd1, 1'b1}) begin
                bad++; $display("FAIL fetch_stall: got state=%0d req=%b want 1/1", state, ifu_req);
            end
        end
        ifu_valid = 1'b1; ifu_inst = e.inst; lsu_done = 1'($urandom); br_taken = 1'($urandom);
        @(posedge clk); @(negedge clk);
        ifu_valid = 1'($urandom); ifu_inst = $urandom;
        total++;
        if ({state, ifu_req, inst} !== {3'd2, 1'b0, e.inst}) begin
            bad++; $display("FAIL decode_entry: got state=%0d req=%b inst=%h want 2/0/%h",
                            state, ifu_req, inst, e.inst);
        end
        @(posedge clk); @(negedge clk);
        if (e.hcode != 2'd0) begin
            total++;
            if ({state, halt, halt_code, ifu_req, lsu_req, pc_wen, rfwen} !== {3'd6, 1'b1, e.hcode, 4'b0}) begin
                bad++; $display("FAIL halt_entry %h: got state=%0d halt=%b code=%0d pcw=%b rfw=%b want 6/1/%0d/0/0",
                                e.inst, state, halt, halt_code, pc_wen, rfwen, e.hcode);
            end
            ifu_valid = 1'b0;
            return;
        end
        total++;
        if (state !== 3'd3 || (e.chk_imm && imm !== e.imm) || (e.chk_alu && alu_op !== e.alu) ||
            (e.chk_mux && {aluamux, alubmux} !== {e.amux, e.bmux}) || (e.chk_wb && wb_sel !== e.wb)) begin
            bad++; $display("FAIL decode %h: got st=%0d imm=%h alu=%0d a=%b b=%b wb=%0d want st=3 imm=%h alu=%0d a=%b b=%b wb=%0d",
                            e.inst, state, imm, alu_op, aluamux, alubmux, wb_sel, e.imm, e.alu, e.amux, e.bmux, e.wb);
        end
        br_taken = br; lsu_done = 1'($urandom);
        @(posedge clk); @(negedge clk);
        br_taken = ~br;
        if (e.mem) begin
            for (int k = 1; k <= int'(TMO); k++) begin
                total++;
                if ({state, lsu_req, lsu_wen, ifu_req, pc_wen} !== {3'd4, 1'b1, e.store, 2'b0}) begin
                    bad++; $display("FAIL mem_cycle%0d: got st=%0d req=%b wen=%b want 4/1/%b",
                                    k, state, lsu_req, lsu_wen, e.store);
                end
                lsu_done = (k == mw);
                @(posedge clk); @(negedge clk);
                if (k == mw) break;
            end
            lsu_done = 1'b0;
            if (mw == 0 || mw > int'(TMO)) begin
                total++;
                if ({state, halt, halt_code, lsu_req, lsu_wen, pc_wen, rfwen, ifu_req} !== {3'd6, 1'b1, 2'd3, 5'b0}) begin
                    bad++; $display("FAIL timeout: got st=%0d halt=%b code=%0d req=%b pcw=%b rfw=%b want 6/1/3/0/0/0",
                                    state, halt, halt_code, lsu_req, pc_wen, rfwen);
                end
                ifu_valid = 1'b0;
                return;
            end
        end
        xpcs = (e.kind == K_BR) ? {1'b0, br} : e.pcs;
        total++;
        if ({state, pc_wen, rfwen, pc_sel, lsu_req, ifu_req} !== {3'd5, 1'b1, e.wr, xpcs, 2'b0} ||
            (e.chk_wb && wb_sel !== e.wb)) begin
            bad++; $display("FAIL wb %h: got st=%0d pcw=%b rfw=%b pcs=%0d wb=%0d want 5/1/%b/%0d/%0d",
                            e.inst, state, pc_wen, rfwen, pc_sel, wb_sel, e.wr, xpcs, e.wb);
        end
        @(posedge clk); @(negedge clk);
        ifu_valid = 1'b0;
        total++;
        if ({state, ifu_req, pc_wen, rfwen} !== {3'd1, 1'b1, 2'b0}) begin
            bad++; $display("FAIL back_to_fetch: got st=%0d req=%b pcw=%b rfw=%b want 1/1/0/0",
                            state, ifu_req, pc_wen, rfwen);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        ifu_valid = 1'b0; lsu_done = 1'b0;
        #1;
        total++;
        if (outs_all !== '0) begin bad++; $display("FAIL reset_async: got %h want 0", outs_all); end
        @(negedge clk); @(negedge clk);
        total++;
        if (outs_all !== '0) begin bad++; $display("FAIL reset_held: got %h want 0", outs_all); end
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        total++;
        if ({state, ifu_req, pc_wen, rfwen, halt} !== {3'd1, 1'b1, 3'b0}) begin
            bad++; $display("FAIL reset_release: got st=%0d req=%b pcw=%b rfw=%b halt=%b want 1/1/0/0/0",
                            state, ifu_req, pc_wen, rfwen, halt);
        end
    endtask

    task automatic hold_halt(input logic [1:0] code);
        for (int i = 0; i < 3; i++) begin
            ifu_valid = 1'b1; lsu_done = 1'b1; ifu_inst = $urandom;
            @(posedge clk); @(negedge clk);
            total++;
            if ({state, halt, halt_code, ifu_req, lsu_req, rfwen, pc_wen} !== {3'd6, 1'b1, code, 4'b0}) begin
                bad++; $display("FAIL halt_hold: got st=%0d halt=%b code=%0d strobes=%b%b%b%b want 6/1/%0d/0000",
                                state, halt, halt_code, ifu_req, lsu_req, rfwen, pc_wen, code);
            end
        end
        ifu_valid = 1'b0; lsu_done = 1'b0;
    endtask

    task automatic test_alu_imm();
        exp_t e;
        gen(K_OPIMM, 1, 0, 0, 5, 0, e);
        run_inst(e, 0, 1'b0, 0);
        gen(K_OPIMM, 0, 0, 0, 1, 0, e);
        run_inst(e, 2, 1'b0, 0);
    endtask

    task automatic test_branch();
        exp_t e;
        gen(K_BR, 0, 0, 0, -8, 0, e);
        run_inst(e, 0, 1'b1, 0);
        run_inst(e, 1, 1'b0, 0);
    endtask

    task automatic test_mem();
        exp_t e;
        gen(K_SW, 0, 2, 1, 0, 0, e);
        run_inst(e, 0, 1'b0, 3);
        gen(K_LW, 1, 1, 0, 0, 0, e);
        run_inst(e, 0, 1'b0, 1);
        run_inst(e, 0, 1'b0, int'(TMO));
    endtask

    task automatic test_random();
        exp_t e;
        int   k;
        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 8));
            gen_rand(k, e);
            run_inst(e, int'($urandom_range(0, 2)), 1'($urandom), int'($urandom_range(1, TMO)));
        end
    endtask

    task automatic test_mid_mem_reset();
        ifu_valid = 1'b1; ifu_inst = 32'h0000A083;
        @(posedge clk); @(negedge clk);
        ifu_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        total++;
        if ({state, lsu_req, lsu_wen} !== {3'd4, 1'b1, 1'b0}) begin
            bad++; $display("FAIL mid_mem_setup: got st=%0d req=%b wen=%b want 4/1/0", state, lsu_req, lsu_wen);
        end
        test_reset();
    endtask

    task automatic test_halts();
        exp_t e;
        mk_halt(32'h00100073, 2'd1, e);
        run_inst(e, 0, 1'b0, 0);
        hold_halt(2'd1);
        test_reset();
        for (int i = 0; i < 7; i++) begin
            mk_halt(ill[i], 2'd2, e);
            run_inst(e, 0, 1'b0, 0);
            if (i == 0) hold_halt(2'd2);
            test_reset();
        end
        gen(K_LW, 1, 1, 0, 0, 0, e);
        run_inst(e, 0, 1'b0, 0);
        hold_halt(2'd3);
        test_reset();
    endtask

    initial begin
        rst = 1'b0; ifu_valid = 1'b0; ifu_inst = '0; lsu_done = 1'b0; br_taken = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu_imm();
        test_branch();
        test_mem();
        test_random();
        test_mid_mem_reset();
        test_halts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/ysyx_23060020_mc_contr.md
Name: ysyx_23060020_mc_contr

Overview:
- Multi-cycle control unit for the RV32I core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with valid/done handshakes to the IFU and LSU.
- Decodes an RV32I subset into datapath controls and immediates, and halts on ebreak, an illegal instruction or an LSU timeout.

Parameters:
- XLEN, 32: datapath width; imm is sign-extended to XLEN; legal values are 32 and 64.
- MEM_TIMEOUT, 255: maximum number of MEM-state cycles to wait for lsu_done before halting; range 1..65535.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ifu_req  out  1  fetch request; held high in FETCH
- ifu_valid  in  1  instruction word valid; sampled only in FETCH
- ifu_inst  in  32  instruction word
- lsu_req  out  1  memory request; held high in MEM
- lsu_wen  out  1  1=store, 0=load; valid while lsu_req=1
- lsu_done  in  1  memory access complete; sampled only in MEM
- br_taken  in  1  ALU compare result; sampled in EXEC
- inst  out  32  latched instruction
- imm  out  XLEN  decoded immediate
- aluamux  out  1  0=rs1, 1=pc
- alubmux  out  1  0=rs2, 1=imm
- alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- wb_sel  out  2  0=alu, 1=mem, 2=pc+4
- pc_sel  out  2  0=pc+4, 1=pc+imm, 2=(rs1+imm)&~1
- rfwen  out  1  register-file write strobe; one-cycle pulse in WB
- pc_wen  out  1  PC update strobe; one-cycle pulse in WB
- halt  out  1  sticky halt flag
- halt_code  out  2  0=running, 1=ebreak, 2=illegal, 3=lsu timeout
- state  out  3  debug: 0 RST, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB, 6 HALT

Behaviour:
- Reset state: RST. All outputs are 0 while rst is high, including inst, imm, halt and halt_code.
- RST -> FETCH on the first clock edge after rst deasserts.
- FETCH:
  - ifu_req=1.
  - On ifu_valid=1: latch ifu_inst into inst, go to DECODE.
  - Otherwise stay in FETCH indefinitely.
- DECODE (1 cycle): register imm, alu_op, aluamux, alubmux, wb_sel and the instruction class. Per-class encoding:
  - OP-IMM: imm=I-type, alubmux=1, funct3/funct7 mapped to alu_op.
  - OP: alubmux=0, funct3/funct7 mapped to alu_op.
  - LUI: imm=U-type, alubmux=1, alu_op=PASSB.
  - AUIPC: imm=U-type, aluamux=1, alubmux=1, alu_op=ADD.
  - JAL: imm=J-type, wb_sel=2, pc_sel=1.
  - JALR: imm=I-type, wb_sel=2, pc_sel=2.
  - BRANCH: imm=B-type, alu_op=SUB/SLT/SLTU per funct3.
  - LW: imm=I-type, alubmux=1, alu_op=ADD, wb_sel=1.
  - SW: imm=S-type, alubmux=1, alu_op=ADD.
  - ebreak (0x00100073): go to HALT with code 1.
  - Any other encoding: go to HALT with code 2.
  - Neither halt case asserts pc_wen or rfwen.
- EXEC (1 cycle):
  - For BRANCH, register pc_sel = br_taken ? 1 : 0.
  - LW/SW go to MEM; all other classes go to WB.
- MEM:
  - lsu_req=1; lsu_wen=1 for SW.
  - On lsu_done=1, go to WB.
  - The wait counter increments each cycle in MEM. When it reaches MEM_TIMEOUT with lsu_done still 0, go to HALT with code 3.
  - If lsu_done=1 arrives in the same cycle as the timeout, lsu_done wins.
- WB (1 cycle):
  - pc_wen=1.
  - rfwen=1 for every class except BRANCH and SW, suppressed when inst[11:7]==0.
  - Then go to FETCH.
- HALT: absorbing state. halt=1; ifu_req, lsu_req, rfwen and pc_wen are held at 0 until rst.
- Latency: a non-memory instruction with ifu_valid in the first FETCH cycle takes 4 cycles; a load/store with lsu_done in the first MEM cycle takes 5 cycles.
- ifu_valid outside FETCH and lsu_done outside MEM are ignored.
- rst asserted mid-instruction: immediate return to RST; no pending strobes are emitted.

Optional Feature:
- Macro: YSYX_23060020_CONTR_PERF_EN.
- Defined:
  - Adds output perf_cycles (64 bits), which counts every non-RST, non-HALT cycle.
  - Adds output perf_instret (64 bits), which increments on each WB cycle.
  - Both counters reset to 0 and freeze in HALT.
- Undefined: neither port nor counter exists.

Test Plan:
- addi x1,x0,5 (0x00500093), ifu_valid immediate -> DECODE shows imm=5, alubmux=1, alu_op=0; WB 3 cycles after FETCH with rfwen=1, pc_wen=1, wb_sel=0.
- addi x0,x0,1 (0x00100013) -> pc_wen=1, rfwen=0.
- beq with br_taken=1 in EXEC, imm=-8 -> imm=0xFFFFFFF8, pc_sel=1, pc_wen=1, rfwen=0; repeat with br_taken=0 -> pc_sel=0.
- sw (0x00112023), lsu_done after 3 MEM cycles -> lsu_req high for 3 cycles with lsu_wen=1, then WB with rfwen=0.
- lw with lsu_done never asserted, MEM_TIMEOUT=4 -> HALT after 4 MEM cycles, halt_code=3, all strobes 0.
- ebreak (0x00100073) -> HALT after DECODE, halt_code=1, no pc_wen; same for 0xFFFFFFFF with halt_code=2; rst asserted mid-MEM -> state=RST, outputs 0.
